// File: rtl/usb_transaction_sequencer.sv
// usb_transaction_sequencer
//   Device-side USB transaction sequencer. It decodes tokens addressed to this
//   device, tracks the DATA0/DATA1 toggles of each endpoint, and drives the
//   handshake/data PIDs to the packet transmitter.
//
// Ports
//   clock48          48 MHz clock; all state changes on its rising edge
//   reset_n          asynchronous active-low reset
//   device_address   currently assigned USB address
//   rx_packet_valid  one-cycle pulse: receiver finished a packet
//   rx_pid/addr/endp fields of the received packet (valid with rx_packet_valid)
//   rx_crc_ok        CRC and PID check of the received packet passed
//   tx_start         one-cycle pulse: send a packet with tx_pid
//   tx_pid           PID to transmit, held until tx_done
//   tx_done          one-cycle pulse: transmitter finished EOP
//   ep_select        endpoint of the current transaction
//   ep_in_ready      per-endpoint IN data available
//   ep_out_space     per-endpoint OUT buffer can take a max packet
//   setup_received, out_commit, out_discard, in_acked
//                    one-cycle event pulses to the endpoint buffers
//
// Build option
//   USB_SEQ_TOGGLE_CHECK_EN : OUT data whose PID does not match the OUT toggle
//   is ACKed but discarded (toggle unchanged). Undefined: OUT data PID is not
//   checked and every accepted OUT packet is committed.
//
// State      | meaning
// IDLE       | waiting for a token addressed to this device
// WAIT_DATA  | SETUP/OUT token accepted, waiting for the data packet
// SEND_HS    | ACK/NAK handed to the transmitter, waiting for tx_done
// SEND_DATA  | IN data packet handed to the transmitter, waiting for tx_done
// WAIT_HS    | IN data sent, waiting for the host handshake
module usb_transaction_sequencer #(
  parameter int NUM_ENDPOINTS  = 2,
  parameter int TIMEOUT_CYCLES = 72
) (
  input  logic                     clock48,
  input  logic                     reset_n,
  input  logic [6:0]               device_address,
  input  logic                     rx_packet_valid,
  input  logic [3:0]               rx_pid,
  input  logic [6:0]               rx_addr,
  input  logic [3:0]               rx_endp,
  input  logic                     rx_crc_ok,
  output logic                     tx_start,
  output logic [3:0]               tx_pid,
  input  logic                     tx_done,
  output logic [3:0]               ep_select,
  input  logic [NUM_ENDPOINTS-1:0] ep_in_ready,
  input  logic [NUM_ENDPOINTS-1:0] ep_out_space,
  output logic                     setup_received,
  output logic                     out_commit,
  output logic                     out_discard,
  output logic                     in_acked
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam int          TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [4:0]  NUM_EP5 = 5'(NUM_ENDPOINTS);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, SEND_HS, SEND_DATA, WAIT_HS} state_t;

  state_t        state_q, state_d;
  logic [3:0]    ep_q, ep_d;
  logic          setup_q, setup_d;
  logic [3:0]    tx_pid_q, tx_pid_d;
  logic          tx_start_q, tx_start_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   in_tog_q, in_tog_d;
  logic [15:0]   out_tog_q, out_tog_d;
  logic          setup_rx_q, setup_rx_d;
  logic          commit_q, commit_d;
  logic          discard_q, discard_d;
  logic          acked_q, acked_d;

  // Widened to 16 so any 4-bit endpoint number indexes them without range issues.
  logic [15:0] in_ready_w, out_space_w;
  logic        tok_ok, is_data, pid_tog;

  assign in_ready_w  = 16'(ep_in_ready);
  assign out_space_w = 16'(ep_out_space);
  assign is_data     = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
  assign pid_tog     = (rx_pid == PID_DATA1);
  assign tok_ok      = rx_packet_valid && rx_crc_ok && (rx_addr == device_address) &&
                       ({1'b0, rx_endp} < NUM_EP5) &&
                       ((rx_pid == PID_SETUP) || (rx_pid == PID_OUT) || (rx_pid == PID_IN));

  always_comb begin
    state_d    = state_q;
    ep_d       = ep_q;
    setup_d    = setup_q;
    tx_pid_d   = tx_pid_q;
    timer_d    = timer_q;
    in_tog_d   = in_tog_q;
    out_tog_d  = out_tog_q;
    tx_start_d = 1'b0;
    setup_rx_d = 1'b0;
    commit_d   = 1'b0;
    discard_d  = 1'b0;
    acked_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tok_ok) begin
          ep_d = rx_endp;
          if (rx_pid == PID_IN) begin
            setup_d    = 1'b0;
            tx_start_d = 1'b1;
            if (in_ready_w[rx_endp]) begin
              state_d  = SEND_DATA;
              tx_pid_d = in_tog_q[rx_endp] ? PID_DATA1 : PID_DATA0;
            end else begin
              state_d  = SEND_HS;
              tx_pid_d = PID_NAK;
            end
          end else begin
            state_d = WAIT_DATA;
            setup_d = (rx_pid == PID_SETUP);
            timer_d = T_LOAD;
          end
        end
      end
      WAIT_DATA: begin
        if (rx_packet_valid) begin
          state_d = IDLE;
          if (!(rx_crc_ok && is_data)) begin
            discard_d = 1'b1;
          end else if (setup_q) begin
            if (rx_pid == PID_DATA0) begin
              state_d         = SEND_HS;
              tx_start_d      = 1'b1;
              tx_pid_d        = PID_ACK;
              setup_rx_d      = 1'b1;
              in_tog_d[ep_q]  = 1'b1;
              out_tog_d[ep_q] = 1'b1;
            end else begin
              discard_d = 1'b1;
            end
          end else begin
            state_d    = SEND_HS;
            tx_start_d = 1'b1;
            if (!out_space_w[ep_q]) begin
              tx_pid_d  = PID_NAK;
              discard_d = 1'b1;
            end else begin
              tx_pid_d = PID_ACK;
`ifdef USB_SEQ_TOGGLE_CHECK_EN
              // Host retry of a packet we already took: ACK it, drop the data.
              if (pid_tog != out_tog_q[ep_q]) begin
                discard_d = 1'b1;
              end else begin
                commit_d        = 1'b1;
                out_tog_d[ep_q] = ~out_tog_q[ep_q];
              end
`else
              commit_d        = 1'b1;
              out_tog_d[ep_q] = ~out_tog_q[ep_q];
`endif
            end
          end
        end else if (timer_q == '0) begin
          state_d   = IDLE;
          discard_d = 1'b1;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      SEND_HS: begin
        if (tx_done) state_d = IDLE;
      end
      SEND_DATA: begin
        if (tx_done) begin
          state_d = WAIT_HS;
          timer_d = T_LOAD;
        end
      end
      WAIT_HS: begin
        if (rx_packet_valid) begin
          state_d = IDLE;
          if (rx_crc_ok && (rx_pid == PID_ACK)) begin
            acked_d        = 1'b1;
            in_tog_d[ep_q] = ~in_tog_q[ep_q];
          end
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ep_q       <= '0;
      setup_q    <= 1'b0;
      tx_pid_q   <= '0;
      tx_start_q <= 1'b0;
      timer_q    <= '0;
      in_tog_q   <= '0;
      out_tog_q  <= '0;
      setup_rx_q <= 1'b0;
      commit_q   <= 1'b0;
      discard_q  <= 1'b0;
      acked_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ep_q       <= ep_d;
      setup_q    <= setup_d;
      tx_pid_q   <= tx_pid_d;
      tx_start_q <= tx_start_d;
      timer_q    <= timer_d;
      in_tog_q   <= in_tog_d;
      out_tog_q  <= out_tog_d;
      setup_rx_q <= setup_rx_d;
      commit_q   <= commit_d;
      discard_q  <= discard_d;
      acked_q    <= acked_d;
    end
  end

  assign tx_start       = tx_start_q;
  assign tx_pid         = tx_pid_q;
  assign ep_select      = ep_q;
  assign setup_received = setup_rx_q;
  assign out_commit     = commit_q;
  assign out_discard    = discard_q;
  assign in_acked       = acked_q;

endmodule
